// File: rtl/or1k_branch_predictor_unit_if.sv
// Decode/execute-side signal bundle for the conditional-branch direction predictor.
// The master drives branch context and resolution; the slave (predictor) returns prediction/mispredict.
interface or1k_branch_predictor_unit_if #(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32
);
  logic                            op_bf;
  logic                            op_bnf;
  logic [9:0]                      immjbr_upper;
  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc;
  logic                            predicted_flag;
  logic                            prev_op_brcond;
  logic                            prev_predicted_flag;
  logic                            flag;
  logic                            padv_decode;
  logic                            execute_bf;
  logic                            execute_bnf;
  logic                            branch_mispredict;

  modport master (
    output op_bf, op_bnf, immjbr_upper, brn_pc, prev_op_brcond, prev_predicted_flag,
           flag, padv_decode, execute_bf, execute_bnf,
    input  predicted_flag, branch_mispredict
  );

  modport slave (
    input  op_bf, op_bnf, immjbr_upper, brn_pc, prev_op_brcond, prev_predicted_flag,
           flag, padv_decode, execute_bf, execute_bnf,
    output predicted_flag, branch_mispredict
  );
endinterface

// File: rtl/or1k_branch_predictor_unit.sv
// OR1K l.bf/l.bnf direction predictor: static backward-taken, one global 2-bit counter,
// or a gshare table of 2-bit counters, selected at elaboration time.
module or1k_branch_predictor_unit #(
  parameter logic [95:0] PREDICTOR_TYPE       = "SIMPLE",
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned GSHARE_BITS_NUM      = 10
) (
  input logic                       clk,
  input logic                       rst,
  or1k_branch_predictor_unit_if.slave bp_io
);

  // Counter encoding: 0 strongly NT, 1 weakly NT, 2 weakly T, 3 strongly T.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic inc);
    if (inc) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    return (cnt == 2'd0) ? cnt : cnt - 2'd1;
  endfunction

  logic taken;
  logic brn_taken;
  logic upd;
  logic unused_imm;

  assign brn_taken = (bp_io.execute_bf & bp_io.flag) | (bp_io.execute_bnf & ~bp_io.flag);
  assign upd       = bp_io.prev_op_brcond & bp_io.padv_decode;

  assign bp_io.predicted_flag    = (bp_io.op_bf & taken) | (bp_io.op_bnf & ~taken);
  assign bp_io.branch_mispredict = bp_io.prev_op_brcond &
                                   (bp_io.flag != bp_io.prev_predicted_flag);

  assign unused_imm = ^bp_io.immjbr_upper;

  if (PREDICTOR_TYPE == "SIMPLE") begin : gen_simple
    logic unused_simple;
    assign unused_simple = ^{upd, brn_taken, bp_io.brn_pc};
    // Backward branches (negative offset) are assumed to close loops.
    assign taken = bp_io.immjbr_upper[9];

  end else if (PREDICTOR_TYPE == "SAT_COUNTER") begin : gen_sat
    logic [1:0] state_q, state_d;
    logic       unused_sat;

    assign unused_sat = ^bp_io.brn_pc;

    always_comb begin
      state_d = state_q;
      if (upd) state_d = sat_next(state_q, brn_taken);
    end

    always_ff @(posedge clk) begin
      if (rst) state_q <= 2'd2;
      else     state_q <= state_d;
    end

    assign taken = state_q[1];

  end else if (PREDICTOR_TYPE == "GSHARE") begin : gen_gshare
    localparam int unsigned TableSize = 1 << GSHARE_BITS_NUM;

    logic [GSHARE_BITS_NUM-1:0] hist_q, hist_d;
    logic [GSHARE_BITS_NUM-1:0] prev_idx_q, prev_idx_d;
    logic [GSHARE_BITS_NUM-1:0] idx;
    logic [1:0]                 cnt_q [TableSize];
    logic                       unused_gshare;

    assign unused_gshare = ^bp_io.brn_pc;
    assign idx           = hist_q ^ bp_io.brn_pc[GSHARE_BITS_NUM+1:2];
    assign taken         = cnt_q[idx][1];

    always_comb begin
      hist_d     = hist_q;
      prev_idx_d = prev_idx_q;
      if (bp_io.op_bf | bp_io.op_bnf) prev_idx_d = idx;
      if (upd) hist_d = {hist_q[GSHARE_BITS_NUM-2:0], brn_taken};
    end

    // The resolving branch trains the entry it was predicted from, i.e. the old prev_idx_q.
    always_ff @(posedge clk) begin
      if (rst) begin
        hist_q     <= '0;
        prev_idx_q <= '0;
        for (int unsigned i = 0; i < TableSize; i++) cnt_q[i] <= 2'd2;
      end else begin
        hist_q     <= hist_d;
        prev_idx_q <= prev_idx_d;
        if (upd) cnt_q[prev_idx_q] <= sat_next(cnt_q[prev_idx_q], brn_taken);
      end
    end

  end else begin : gen_bad_type
    $fatal(1, "or1k_branch_predictor_unit: unsupported PREDICTOR_TYPE");
  end

endmodule

// File: tb/tb_or1k_branch_predictor_unit.sv
// Directed bench for all three predictor flavours: combinational table, then counter/gshare sequences.
module tb_or1k_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_bf, op_bnf, prev_brcond, prev_pred, flag, padv, ex_bf, ex_bnf;
  logic [9:0]  imm;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  or1k_branch_predictor_unit_if #(.OPTION_OPERAND_WIDTH(32)) if_s ();
  or1k_branch_predictor_unit_if #(.OPTION_OPERAND_WIDTH(32)) if_c ();
  or1k_branch_predictor_unit_if #(.OPTION_OPERAND_WIDTH(32)) if_g ();

  assign if_s.op_bf = op_bf;               assign if_c.op_bf = op_bf;
  assign if_g.op_bf = op_bf;               assign if_s.op_bnf = op_bnf;
  assign if_c.op_bnf = op_bnf;             assign if_g.op_bnf = op_bnf;
  assign if_s.immjbr_upper = imm;          assign if_c.immjbr_upper = imm;
  assign if_g.immjbr_upper = imm;          assign if_s.brn_pc = pc;
  assign if_c.brn_pc = pc;                 assign if_g.brn_pc = pc;
  assign if_s.prev_op_brcond = prev_brcond; assign if_c.prev_op_brcond = prev_brcond;
  assign if_g.prev_op_brcond = prev_brcond; assign if_s.prev_predicted_flag = prev_pred;
  assign if_c.prev_predicted_flag = prev_pred; assign if_g.prev_predicted_flag = prev_pred;
  assign if_s.flag = flag;                 assign if_c.flag = flag;
  assign if_g.flag = flag;                 assign if_s.padv_decode = padv;
  assign if_c.padv_decode = padv;          assign if_g.padv_decode = padv;
  assign if_s.execute_bf = ex_bf;          assign if_c.execute_bf = ex_bf;
  assign if_g.execute_bf = ex_bf;          assign if_s.execute_bnf = ex_bnf;
  assign if_c.execute_bnf = ex_bnf;        assign if_g.execute_bnf = ex_bnf;

  or1k_branch_predictor_unit #(.PREDICTOR_TYPE("SIMPLE")) u_simple (
    .clk(clk), .rst(rst), .bp_io(if_s)
  );
  or1k_branch_predictor_unit #(.PREDICTOR_TYPE("SAT_COUNTER")) u_sat (
    .clk(clk), .rst(rst), .bp_io(if_c)
  );
  or1k_branch_predictor_unit #(.PREDICTOR_TYPE("GSHARE")) u_gshare (
    .clk(clk), .rst(rst), .bp_io(if_g)
  );

  typedef struct {
    logic bf, bnf, imm9, brcond, ppred, flg;
    logic exp_simple, exp_misp;
  } vec_t;

  vec_t vecs [8];

  function automatic logic pred_model(input logic bf, input logic bnf, input logic t);
    return (bf & t) | (bnf & ~t);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic resolve(input logic bf, input logic bnf, input logic flg, input logic adv);
    prev_brcond = 1'b1; ex_bf = bf; ex_bnf = bnf; flag = flg; padv = adv;
    @(posedge clk); #1;
    prev_brcond = 1'b0; ex_bf = 1'b0; ex_bnf = 1'b0; flag = 1'b0; padv = 1'b0;
  endtask

  initial begin
    rst = 1'b0; op_bf = 1'b0; op_bnf = 1'b0; prev_brcond = 1'b0; prev_pred = 1'b0;
    flag = 1'b0; padv = 1'b0; ex_bf = 1'b0; ex_bnf = 1'b0; imm = 10'h000; pc = 32'h100;

    //            bf    bnf   imm9  brcond ppred flag  simple misp
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    #2;
    do_reset();

    // padv stays low, so none of these rows may disturb predictor state.
    for (int i = 0; i < 8; i++) begin
      op_bf = vecs[i].bf; op_bnf = vecs[i].bnf; imm = {vecs[i].imm9, 9'h055};
      prev_brcond = vecs[i].brcond; prev_pred = vecs[i].ppred; flag = vecs[i].flg;
      #1;
      check($sformatf("vec%0d simple pred", i), if_s.predicted_flag, vecs[i].exp_simple);
      check($sformatf("vec%0d simple misp", i), if_s.branch_mispredict, vecs[i].exp_misp);
      check($sformatf("vec%0d gshare misp", i), if_g.branch_mispredict, vecs[i].exp_misp);
      check($sformatf("vec%0d sat pred", i), if_c.predicted_flag,
            pred_model(vecs[i].bf, vecs[i].bnf, 1'b1));
      check($sformatf("vec%0d gshare pred", i), if_g.predicted_flag,
            pred_model(vecs[i].bf, vecs[i].bnf, 1'b1));
      @(posedge clk); #1;
    end
    prev_brcond = 1'b0; prev_pred = 1'b0; flag = 1'b0;

    // Counter saturation with l.bf in decode.
    op_bf = 1'b1; op_bnf = 1'b0; imm = 10'h000;
    do_reset();
    check("sat after reset", if_c.predicted_flag, 1'b1);
    resolve(1'b1, 1'b0, 1'b0, 1'b1);
    check("sat 2->1", if_c.predicted_flag, 1'b0);
    resolve(1'b1, 1'b0, 1'b0, 1'b1);
    check("sat 1->0", if_c.predicted_flag, 1'b0);
    resolve(1'b1, 1'b0, 1'b0, 1'b1);
    check("sat floor", if_c.predicted_flag, 1'b0);
    resolve(1'b1, 1'b0, 1'b1, 1'b1);
    check("sat 0->1", if_c.predicted_flag, 1'b0);
    resolve(1'b1, 1'b0, 1'b1, 1'b1);
    check("sat 1->2", if_c.predicted_flag, 1'b1);
    resolve(1'b1, 1'b0, 1'b1, 1'b1);
    check("sat 2->3", if_c.predicted_flag, 1'b1);
    resolve(1'b1, 1'b0, 1'b1, 1'b1);
    check("sat ceiling", if_c.predicted_flag, 1'b1);
    resolve(1'b0, 1'b1, 1'b1, 1'b1);
    check("sat 3->2 via bnf", if_c.predicted_flag, 1'b1);
    resolve(1'b1, 1'b0, 1'b0, 1'b1);
    check("sat 2->1 after ceiling", if_c.predicted_flag, 1'b0);

    // Stalled decode must freeze the counter.
    do_reset();
    for (int i = 0; i < 5; i++) resolve(1'b1, 1'b0, 1'b0, 1'b0);
    check("sat stall hold", if_c.predicted_flag, 1'b1);
    resolve(1'b1, 1'b0, 1'b0, 1'b1);
    check("sat after stall release", if_c.predicted_flag, 1'b0);

    // gshare: PC 0x100 -> idx 0x040 while hist is zero.
    pc = 32'h100; op_bf = 1'b1; op_bnf = 1'b0;
    do_reset();
    check("gshare after reset", if_g.predicted_flag, 1'b1);
    idle_cycle();
    resolve(1'b1, 1'b0, 1'b0, 1'b1);
    check("gshare entry 2->1", if_g.predicted_flag, 1'b0);
    resolve(1'b1, 1'b0, 1'b0, 1'b1);
    check("gshare entry 1->0", if_g.predicted_flag, 1'b0);
    op_bf = 1'b0; op_bnf = 1'b1; #1;
    check("gshare bnf on trained entry", if_g.predicted_flag, 1'b1);
    op_bf = 1'b1; op_bnf = 1'b0;
    resolve(1'b1, 1'b0, 1'b1, 1'b1);
    check("gshare hist moves idx to 0x041", if_g.predicted_flag, 1'b1);

    // gshare reset mid-run: table and history both return to their initial values.
    do_reset();
    idle_cycle();
    resolve(1'b1, 1'b0, 1'b0, 1'b1);
    resolve(1'b1, 1'b0, 1'b0, 1'b1);
    check("gshare retrained to 0", if_g.predicted_flag, 1'b0);
    resolve(1'b1, 1'b0, 1'b1, 1'b1);
    do_reset();
    pc = 32'h100; #1;
    check("gshare table reset", if_g.predicted_flag, 1'b1);
    idle_cycle();
    resolve(1'b1, 1'b0, 1'b0, 1'b1);
    check("gshare hist reset", if_g.predicted_flag, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
